// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - character constants and parser state encoding shared by receive-side blocks
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    SKIP  = 2'd3
  } state_t;

endpackage

// File: rtl/ascii_to_nibble.sv
// rtl/ascii_to_nibble.sv - ASCII character to BCD digit converter with digit flag
module ascii_to_nibble
  import ascii_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_digit
);

  // Non-digit characters map to nibble 0 so the output is always defined.
  assign is_digit = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
  assign nibble   = is_digit ? ch[3:0] : 4'h0;

endmodule

// File: rtl/ascii_bcd_parser.sv
// rtl/ascii_bcd_parser.sv - ASCII digit stream to packed BCD word parser; optional sign via ASCII_PARSER_SIGN_EN
module ascii_bcd_parser
  import ascii_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*NDIGITS-1:0]           out_bcd,
  output logic [$clog2(NDIGITS+1)-1:0]   out_ndig,
  output logic                           err
`ifdef ASCII_PARSER_SIGN_EN
  ,
  output logic                           out_neg
`endif
);

  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIGITS);

  state_t          state_q, state_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  logic            fault;
  logic [3:0]      nib;
  logic            is_digit;
  logic            is_term;
  logic            is_minus;
  logic            accept;

  ascii_to_nibble u_conv (
    .ch       (in_data),
    .nibble   (nib),
    .is_digit (is_digit)
  );

  assign accept  = in_valid && in_ready;
  assign is_term = (in_data == ASCII_CR) || (in_data == ASCII_LF);
`ifdef ASCII_PARSER_SIGN_EN
  assign is_minus = (in_data == ASCII_MINUS);
`else
  assign is_minus = 1'b0;
`endif

  // Next-state logic: digit accumulation, termination, error handling and result hand-off.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    err_d   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              fault = 1'b1;
            end else begin
              bcd_d   = {bcd_q[BW-5:0], nib};
              cnt_d   = cnt_q + 1'b1;
              state_d = ACCUM;
            end
          end else if (is_term) begin
            // Terminator in IDLE is an empty line (e.g. LF of CR-LF) and is dropped.
            if (state_q == ACCUM) begin
              if (cnt_q == '0) begin
                // Only a sign was received: report it but there is nothing left to skip.
                err_d   = 1'b1;
                neg_d   = 1'b0;
                state_d = IDLE;
              end else begin
                state_d = HOLD;
              end
            end
          end else if (is_minus && (state_q == IDLE)) begin
            neg_d   = 1'b1;
            state_d = ACCUM;
          end else begin
            fault = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          bcd_d   = '0;
          cnt_d   = '0;
          neg_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SKIP: begin
        if (accept && is_term) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fault) begin
      err_d   = 1'b1;
      bcd_d   = '0;
      cnt_d   = '0;
      neg_d   = 1'b0;
      state_d = SKIP;
    end
  end

  // State and datapath registers; reset discards any partial line or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_bcd   = bcd_q;
  assign out_ndig  = cnt_q;
  assign err       = err_q;
`ifdef ASCII_PARSER_SIGN_EN
  assign out_neg   = neg_q;
`endif

endmodule

// File: tb/tb_ascii_bcd_parser.sv
// tb/tb_ascii_bcd_parser.sv - self-checking bench for ascii_bcd_parser; sign cases under ASCII_PARSER_SIGN_EN
module tb_ascii_bcd_parser;

  localparam int NDIGITS = 4;
`ifdef ASCII_PARSER_SIGN_EN
  localparam bit SIGN = 1'b1;
`else
  localparam bit SIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_bcd;
  logic [2:0]  out_ndig;
  logic        err;
  logic        out_neg_s;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int clash = 0;
  bit ov_prev = 1'b0;
  bit rnd_ready = 1'b0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          m_digits[$];
  bit          m_neg = 1'b0;
  bit          m_bad = 1'b0;
  int          m_err = 0;

`ifdef ASCII_PARSER_SIGN_EN
  logic out_neg;
  assign out_neg_s = out_neg;
`else
  assign out_neg_s = 1'b0;
`endif

  ascii_bcd_parser #(.NDIGITS(NDIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ndig  (out_ndig),
    .err       (err)
`ifdef ASCII_PARSER_SIGN_EN
    ,
    .out_neg   (out_neg)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ent(input bit neg, input int nd, input int bcd);
    return {11'b0, neg, 1'b0, 3'(nd), 16'(bcd)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(ent(out_neg_s, int'(out_ndig), int'(out_bcd)));
      if (err) err_seen++;
      if (err && out_valid && !ov_prev) clash++;
    end
    ov_prev = out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    got_q.delete();
    err_seen = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the character was taken.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = c;
    forever begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      n++;
      if (n > 100) break;
    end
    if (n > 100) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Reference: one line at a time, digits kept as a list of decimal values.
  task automatic model_char(input logic [7:0] c);
    bit dig, term;
    int value;
    dig  = (c >= 8'h30) && (c <= 8'h39);
    term = (c == 8'h0D) || (c == 8'h0A);
    if (m_bad) begin
      if (term) m_bad = 1'b0;
      return;
    end
    if (dig) begin
      if (m_digits.size() == NDIGITS) begin
        m_err++; m_bad = 1'b1; m_digits.delete(); m_neg = 1'b0;
      end else begin
        m_digits.push_back(int'(c) - 48);
      end
    end else if (term) begin
      if (m_digits.size() > 0) begin
        value = 0;
        foreach (m_digits[i]) value += m_digits[i] * (16 ** (m_digits.size() - 1 - i));
        exp_q.push_back(ent(m_neg, m_digits.size(), value));
        m_digits.delete(); m_neg = 1'b0;
      end else if (m_neg) begin
        m_err++; m_neg = 1'b0;
      end
    end else if (SIGN && c == 8'h2D && !m_neg && m_digits.size() == 0) begin
      m_neg = 1'b1;
    end else begin
      m_err++; m_bad = 1'b1; m_digits.delete(); m_neg = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] c;
    int nchk;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    chk("rst_ndig", 32'(out_ndig), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // "123" CR, then a lone LF
    clear_mon();
    out_ready = 1'b1;
    send_str("123");
    send(8'h0D);
    @(negedge clk);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_bcd", 32'(out_bcd), 32'h0123);
    chk("t1_ndig", 32'(out_ndig), 32'd3);
    @(posedge clk); #1;
    send(8'h0A);
    idle(3);
    chk("t1_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t1_word", got_q[0], ent(1'b0, 3, 'h0123));
    chk("t1_err", 32'(err_seen), 32'd0);

    // "9876" LF held under back-pressure with '5' waiting
    clear_mon();
    out_ready = 1'b0;
    send_str("9876");
    send(8'h0A);
    in_valid = 1'b1;
    in_data  = 8'h35;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_bcd", 32'(out_bcd), 32'h9876);
      chk("t2_hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t2_rel_ready", 32'(in_ready), 32'd1);
    chk("t2_rel_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_five_bcd", 32'(out_bcd), 32'h0005);
    chk("t2_five_ndig", 32'(out_ndig), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h0D);
    idle(3);
    chk("t2_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      chk("t2_word0", got_q[0], ent(1'b0, 4, 'h9876));
      chk("t2_word1", got_q[1], ent(1'b0, 1, 'h0005));
    end

    // Overflow: "12345" CR, then "7" CR
    clear_mon();
    send_str("12345");
    @(negedge clk);
    chk("t3_err_pulse", 32'(err), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_err_width", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(8'h0D);
    idle(3);
    chk("t3_ovf_count", 32'(got_q.size()), 32'd0);
    chk("t3_ovf_errs", 32'(err_seen), 32'd1);
    clear_mon();
    send(8'h37);
    send(8'h0D);
    idle(3);
    chk("t3_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t3_word", got_q[0], ent(1'b0, 1, 'h0007));

    // Illegal character: "4A2" CR
    clear_mon();
    send_str("4A2");
    send(8'h0D);
    idle(3);
    chk("t4_errs", 32'(err_seen), 32'd1);
    chk("t4_count", 32'(got_q.size()), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd1);
    chk("t4_bcd", 32'(out_bcd), 32'd0);
    chk("t4_ndig", 32'(out_ndig), 32'd0);

    // Asynchronous reset mid-line and with a pending result
    send_str("56");
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_ndig", 32'(out_ndig), 32'd0);
    chk("t5_bcd", 32'(out_bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h39);
    send(8'h0D);
    @(negedge clk);
    chk("t5_pend_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_pend_drop", 32'(out_valid), 32'd0);
    chk("t5_pend_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    clear_mon();
    send(8'h38);
    send(8'h0D);
    idle(3);
    chk("t5_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t5_word", got_q[0], ent(1'b0, 1, 'h0008));

`ifdef ASCII_PARSER_SIGN_EN
    // Signed entry and lone sign
    clear_mon();
    send_str("-40");
    send(8'h0D);
    idle(3);
    chk("t6_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t6_word", got_q[0], ent(1'b1, 2, 'h0040));
    clear_mon();
    send(8'h2D);
    send(8'h0D);
    idle(3);
    chk("t6_lone_errs", 32'(err_seen), 32'd1);
    chk("t6_lone_count", 32'(got_q.size()), 32'd0);
`endif

    // Randomized stream against the reference model
    clear_mon();
    exp_q.delete();
    m_digits.delete();
    m_neg = 1'b0; m_bad = 1'b0; m_err = 0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        10, 11:  c = 8'h0D;
        12:      c = 8'h0A;
        13:      c = 8'h2D;
        14:      c = 8'($urandom_range(32, 126));
        default: c = 8'h30 + 8'($urandom_range(0, 9));
      endcase
      model_char(c);
      send(c);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    model_char(8'h0D);
    send(8'h0D);
    model_char(8'h0D);
    send(8'h0D);
    idle(4);
    chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    nchk = exp_q.size();
    for (int i = 0; i < nchk; i++)
      chk("rnd_word", (i < got_q.size()) ? got_q[i] : 32'hdead_beef, exp_q[i]);
    chk("rnd_errs", 32'(err_seen), 32'(m_err));
    chk("err_vs_valid", 32'(clash), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
